// File: rtl/ctr_sched_pkg.sv
// ctr_sched_pkg
// Shared definitions for the shared-counter command scheduler:
//   - opcode encodings carried on req_op
//   - scheduler FSM state encoding
//   - default parameter values for widths and requester count
package ctr_sched_pkg;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_WIDTH = 4;
    localparam int DEF_RPT_W = 4;

    localparam logic [1:0] OP_CLR  = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_UP   = 2'b10;
    localparam logic [1:0] OP_DOWN = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        SETTLE = 2'd2
    } sched_state_t;

endpackage

// File: rtl/ctr_cmd_scheduler_rr_arbiter.sv
// rr_arbiter
// Purely combinational round-robin arbiter. The search begins at i_ptr and
// wraps modulo NREQ; the first asserted request wins. The caller owns the
// pointer register, so this block can be reused by any shared-resource
// controller.
// Ports:
//   i_req      NREQ  request vector
//   i_ptr      ID_W  index where the search starts
//   i_grant_en 1     allow a grant this cycle
//   o_grant    NREQ  one-hot grant (zero when disabled or no request)
//   o_idx      ID_W  encoded winner index (meaningful when o_valid)
//   o_valid    1     a grant is being issued
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [ID_W-1:0] i_ptr,
    input  logic            i_grant_en,
    output logic [NREQ-1:0] o_grant,
    output logic [ID_W-1:0] o_idx,
    output logic            o_valid
);

    logic            w_found;
    logic [ID_W-1:0] w_idx;
    logic [ID_W-1:0] w_cand;

    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = ID_W'((int'(i_ptr) + k) % NREQ);
            if (!w_found && i_req[w_cand]) begin
                w_found = 1'b1;
                w_idx   = w_cand;
            end
        end
    end

    always_comb begin
        o_grant = '0;
        if (i_grant_en && w_found) begin
            o_grant[w_idx] = 1'b1;
        end
    end

    assign o_idx   = w_idx;
    assign o_valid = i_grant_en && w_found;

endmodule

// File: rtl/ctr_cmd_scheduler.sv
// ctr_cmd_scheduler
// Time-shares one up/down/load counter among NREQ requesters. A round-robin
// winner is accepted in IDLE, the counter pins are driven for the command's
// steps in RUN, and SETTLE reports the resulting count with a one-cycle
// done pulse.
//
// state  | meaning
// IDLE   | arbitrate; pulse req_ready to the winner and latch its command
// RUN    | drive counter pins; UP/DOWN repeat rpt+1 times, CLR/LOAD once
// SETTLE | counter idle; ctr_out holds the final value, pulse done_valid
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   req_valid/req_ready          per-requester handshake (ready one-hot)
//   req_op/req_data/req_rpt      packed per-requester command payloads
//   ctr_enable/ctr_rst/ctr_load  counter control pins (sole driver)
//   ctr_up_down/ctr_in           counter direction and load data
//   ctr_out                      counter value
//   done_valid/done_id/done_value completion pulse, winner id, final count
module ctr_cmd_scheduler
    import ctr_sched_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH,
    parameter int RPT_W = DEF_RPT_W,
    parameter int ID_W  = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [2*NREQ-1:0]      req_op,
    input  logic [WIDTH*NREQ-1:0]  req_data,
    input  logic [RPT_W*NREQ-1:0]  req_rpt,
    output logic                   ctr_enable,
    output logic                   ctr_rst,
    output logic                   ctr_load,
    output logic                   ctr_up_down,
    output logic [WIDTH-1:0]       ctr_in,
    input  logic [WIDTH-1:0]       ctr_out,
    output logic                   done_valid,
    output logic [ID_W-1:0]        done_id,
    output logic [WIDTH-1:0]       done_value
);

    sched_state_t     r_state;
    sched_state_t     w_state_nxt;
    logic [ID_W-1:0]  r_rr_ptr;
    logic [ID_W-1:0]  r_id;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_data;
    logic [RPT_W-1:0] r_remaining;
    logic [ID_W-1:0]  r_done_id;
    logic [WIDTH-1:0] r_done_value;

    logic             w_grant_en;
    logic [NREQ-1:0]  w_grant;
    logic [ID_W-1:0]  w_grant_idx;
    logic             w_grant_valid;
    logic [ID_W-1:0]  w_ptr_nxt;
    logic [1:0]       w_sel_op;
    logic [WIDTH-1:0] w_sel_data;
    logic [RPT_W-1:0] w_sel_rpt;

    assign w_grant_en = (r_state == IDLE) && !rst;

    rr_arbiter #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_arb (
        .i_req      (req_valid),
        .i_ptr      (r_rr_ptr),
        .i_grant_en (w_grant_en),
        .o_grant    (w_grant),
        .o_idx      (w_grant_idx),
        .o_valid    (w_grant_valid)
    );

    assign w_ptr_nxt = (w_grant_idx == ID_W'(NREQ - 1)) ? '0 : w_grant_idx + 1'b1;

    // Mux the winner's payload out of the packed request buses.
    always_comb begin
        w_sel_op   = '0;
        w_sel_data = '0;
        w_sel_rpt  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant_idx == ID_W'(i)) begin
                w_sel_op   = req_op[2*i +: 2];
                w_sel_data = req_data[WIDTH*i +: WIDTH];
                w_sel_rpt  = req_rpt[RPT_W*i +: RPT_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_grant_valid) w_state_nxt = RUN;
            RUN:     if (r_remaining == '0) w_state_nxt = SETTLE;
            SETTLE:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Command latch, step counting and completion record.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr     <= '0;
            r_id         <= '0;
            r_op         <= OP_CLR;
            r_data       <= '0;
            r_remaining  <= '0;
            r_done_id    <= '0;
            r_done_value <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_valid) begin
                        r_rr_ptr    <= w_ptr_nxt;
                        r_id        <= w_grant_idx;
                        r_op        <= w_sel_op;
                        r_data      <= w_sel_data;
                        // op[1] marks UP/DOWN, the only ops that repeat.
                        r_remaining <= w_sel_op[1] ? w_sel_rpt : '0;
                    end
                end
                RUN: begin
                    if (r_remaining != '0) begin
                        r_remaining <= r_remaining - 1'b1;
                    end
                end
                SETTLE: begin
                    r_done_id    <= r_id;
                    r_done_value <= ctr_out;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        req_ready   = '0;
        ctr_enable  = 1'b0;
        ctr_rst     = 1'b0;
        ctr_load    = 1'b0;
        ctr_up_down = 1'b0;
        ctr_in      = '0;
        done_valid  = 1'b0;
        done_id     = r_done_id;
        done_value  = r_done_value;
        if (rst) begin
            // Hold the shared counter cleared for as long as reset is high.
            ctr_enable = 1'b1;
            ctr_rst    = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    req_ready = w_grant;
                end
                RUN: begin
                    ctr_enable = 1'b1;
                    case (r_op)
                        OP_CLR:  ctr_rst = 1'b1;
                        OP_LOAD: begin
                            ctr_load = 1'b1;
                            ctr_in   = r_data;
                        end
                        default: ctr_up_down = ~r_op[0];
                    endcase
                end
                SETTLE: begin
                    // The last RUN step is already visible on ctr_out here.
                    done_valid = 1'b1;
                    done_id    = r_id;
                    done_value = ctr_out;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ctr_cmd_scheduler.sv
module tb_ctr_cmd_scheduler;

    localparam int NREQ  = 4;
    localparam int WIDTH = 4;
    localparam int RPT_W = 4;
    localparam int ID_W  = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [2*NREQ-1:0]     req_op;
    logic [WIDTH*NREQ-1:0] req_data;
    logic [RPT_W*NREQ-1:0] req_rpt;
    logic                  ctr_enable, ctr_rst, ctr_load, ctr_up_down;
    logic [WIDTH-1:0]      ctr_in, ctr_out;
    logic                  done_valid;
    logic [ID_W-1:0]       done_id;
    logic [WIDTH-1:0]      done_value;

    always #5 clk = ~clk;

    ctr_cmd_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .RPT_W(RPT_W), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_data(req_data), .req_rpt(req_rpt),
        .ctr_enable(ctr_enable), .ctr_rst(ctr_rst), .ctr_load(ctr_load),
        .ctr_up_down(ctr_up_down), .ctr_in(ctr_in), .ctr_out(ctr_out),
        .done_valid(done_valid), .done_id(done_id), .done_value(done_value)
    );

    // Stand-in for the external counter datapath.
    logic [WIDTH-1:0] cnt;
    logic             preset_en;
    logic [WIDTH-1:0] preset_val;
    always_ff @(posedge clk) begin
        if (preset_en)       cnt <= preset_val;
        else if (ctr_enable) begin
            if (ctr_rst)          cnt <= '0;
            else if (ctr_load)    cnt <= ctr_in;
            else if (ctr_up_down) cnt <= cnt + 1'b1;
            else                  cnt <= cnt - 1'b1;
        end
    end
    assign ctr_out = cnt;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Requester i holds valid while it has issued more commands than were granted.
    logic [1:0]       p_op   [NREQ];
    logic [WIDTH-1:0] p_data [NREQ];
    logic [RPT_W-1:0] p_rpt  [NREQ];
    int               n_iss  [NREQ];
    int               n_gnt  [NREQ];
    always_comb begin
        req_valid = '0;
        req_op    = '0;
        req_data  = '0;
        req_rpt   = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]                 = (n_iss[i] != n_gnt[i]);
            req_op[2*i +: 2]             = p_op[i];
            req_data[WIDTH*i +: WIDTH]   = p_data[i];
            req_rpt[RPT_W*i +: RPT_W]    = p_rpt[i];
        end
    end

    typedef struct {
        int               id;
        logic [WIDTH-1:0] val;
        int               due;
    } exp_t;

    exp_t             done_q[$];
    int               grant_q[$];
    logic [WIDTH-1:0] mdl;
    int               n_pass = 0;
    int               n_total = 0;
    int               n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input int id, input logic [1:0] op, input logic [WIDTH-1:0] data,
                         input logic [RPT_W-1:0] rpt);
        p_op[id]   = op;
        p_data[id] = data;
        p_rpt[id]  = rpt;
        grant_q.push_back(id);
        n_iss[id]++;
    endtask

    task automatic rst_checks();
        chk("rst_ready", req_ready, 0);
        chk("rst_done_valid", done_valid, 0);
        chk("rst_ctr_enable", ctr_enable, 1);
        chk("rst_ctr_rst", ctr_rst, 1);
    endtask

    // Two reset edges; returns at posedge+1 with rst released.
    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        grant_q.delete();
        done_q.delete();
        mdl = '0;
        repeat (2) begin
            @(negedge clk);
            rst_checks();
            @(posedge clk); #1;
        end
        rst = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (grant_q.size() == 0 && done_q.size() == 0 && req_valid == '0) begin
                ok = 1'b1;
                break;
            end
        end
        chk(tag, ok, 1);
        @(posedge clk); #1;
    endtask

    // Scoreboard: grants pop the expected-grant queue and push the expected
    // completion; done pulses pop and compare it.
    task automatic monitor();
        int               gw;
        int               ew;
        int               pend;
        int               steps;
        logic [WIDTH-1:0] v;
        exp_t             e;
        pend = -1;
        forever begin
            @(posedge clk); #1;
            if (pend >= 0) begin
                n_gnt[pend]++;
                pend = -1;
            end
            @(negedge clk);
            if (req_ready != '0) begin
                gw = 0;
                for (int i = 0; i < NREQ; i++) if (req_ready[i]) gw = i;
                chk("ready_onehot", $countones(req_ready), 1);
                chk("ready_without_valid", req_ready & ~req_valid, 0);
                chk("grant_expected", grant_q.size() != 0, 1);
                if (grant_q.size() != 0) begin
                    ew = grant_q.pop_front();
                    chk("grant_id", gw, ew);
                    case (p_op[ew])
                        2'b00:   begin v = '0;                                 steps = 1; end
                        2'b01:   begin v = p_data[ew];                         steps = 1; end
                        2'b10:   begin v = mdl + WIDTH'(p_rpt[ew]) + 1'b1;     steps = int'(p_rpt[ew]) + 1; end
                        default: begin v = mdl - WIDTH'(p_rpt[ew]) - 1'b1;     steps = int'(p_rpt[ew]) + 1; end
                    endcase
                    mdl = v;
                    e.id  = ew;
                    e.val = v;
                    e.due = cyc + steps + 1;
                    done_q.push_back(e);
                end
                pend = gw;
            end
            if (done_valid) begin
                chk("done_expected", done_q.size() != 0, 1);
                if (done_q.size() != 0) begin
                    e = done_q.pop_front();
                    chk("done_id", done_id, e.id);
                    chk("done_value", done_value, e.val);
                    chk("done_cycle", cyc, e.due);
                    chk("settle_ctr_enable", ctr_enable, 0);
                end
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        preset_en  = 1'b1;
        preset_val = 4'h9;
        mdl        = '0;
        for (int i = 0; i < NREQ; i++) begin
            p_op[i] = '0; p_data[i] = '0; p_rpt[i] = '0;
            n_iss[i] = 0; n_gnt[i] = 0;
        end
        fork
            monitor();
        join_none

        // Reset with counter preloaded to 9 and requester 1 already pending.
        p_op[1] = 2'b01; p_data[1] = 4'h5; p_rpt[1] = '0;
        n_iss[1]++;
        @(posedge clk); #1;
        preset_en = 1'b0;
        repeat (2) begin
            @(negedge clk);
            rst_checks();
            @(posedge clk); #1;
        end
        rst = 1'b0;
        grant_q.push_back(1);
        @(negedge clk);
        chk("post_reset_cnt", cnt, 0);
        chk("first_cycle_ready", req_ready, 4'b0010);
        chk("post_reset_done_id", done_id, 0);
        chk("post_reset_done_value", done_value, 0);
        wait_idle("s1_load_idle");

        // UP with wrap: E -> F -> 0 -> 1 -> 2.
        issue(0, 2'b01, 4'hE, 4'd0);
        wait_idle("s2_load_idle");
        issue(0, 2'b10, 4'h0, 4'd3);
        wait_idle("s2_up_idle");
        chk("s2_cnt", cnt, 4'h2);

        // Round robin from pointer 0: 0,2,3 then a full pass 0,1,2,3.
        do_reset();
        issue(0, 2'b01, 4'h3, 4'd0);
        issue(2, 2'b10, 4'h0, 4'd0);
        issue(3, 2'b11, 4'h0, 4'd1);
        @(negedge clk);
        chk("s3_reset_cnt", cnt, 0);
        wait_idle("s3_rr_idle");
        issue(0, 2'b00, 4'h0, 4'd0);
        issue(1, 2'b01, 4'h7, 4'd0);
        issue(2, 2'b10, 4'h0, 4'd1);
        issue(3, 2'b11, 4'h0, 4'd0);
        wait_idle("s3_pass_idle");
        chk("s3_cnt", cnt, 4'h8);

        // DOWN with wrap: 1 -> 0 -> F -> E.
        issue(2, 2'b01, 4'h1, 4'd0);
        wait_idle("s4_load_idle");
        issue(2, 2'b11, 4'h0, 4'd2);
        wait_idle("s4_down_idle");
        chk("s4_cnt", cnt, 4'hE);

        // Reset in the middle of a long UP aborts it; requester 1 wins again.
        issue(1, 2'b10, 4'h0, 4'd7);
        begin
            bit granted;
            granted = 1'b0;
            for (int k = 0; k < 50; k++) begin
                @(negedge clk);
                if (grant_q.size() == 0) begin
                    granted = 1'b1;
                    break;
                end
            end
            chk("s5_granted", granted, 1);
        end
        repeat (3) @(posedge clk);
        #1;
        n_iss[1]++;
        p_op[3] = 2'b11; p_data[3] = 4'h0; p_rpt[3] = 4'd0;
        n_iss[3]++;
        do_reset();
        grant_q.push_back(1);
        grant_q.push_back(3);
        @(negedge clk);
        chk("s5_reset_cnt", cnt, 0);
        wait_idle("s5_regrant_idle");
        chk("s5_cnt", cnt, 4'h7);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired passed=%0d total=%0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule
